// File: rtl/mem_access.sv
// RV64/RV32 memory-access stage: drives the data-memory req/gnt/rvalid bus and registers the writeback bundle.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing them to natural alignment.
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic            reg_write_enable,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            trap_in,
  input  logic [3:0]      trap_cause_in,
  input  logic            flush,
  output logic            mem_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_enable_out,
  output logic [XLEN-1:0] pc_out,
  output logic            trap_out,
  output logic [3:0]      trap_cause_out
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} state_t;

  state_t          state;
  logic [OW-1:0]   off_r;
  logic [2:0]      funct3_r;
  logic [4:0]      rd_r;
  logic            rwe_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] addr_r;

  logic [OW-1:0]   offset_s;
  logic [OW-1:0]   size_mask_s;
  logic [OW-1:0]   eff_off_s;
  logic            misaligned_s;
  logic            misalign_trap_s;
  logic [NB-1:0]   strb_base_s;
  logic [XLEN-1:0] rdata_shift_s;
  logic [XLEN-1:0] load_val_s;

  // Shift the access size up to the MSB, then shift back down logically or arithmetically.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    logic [XLEN-1:0] up;
    int sh;
    case (f3[1:0])
      2'b00:   sh = XLEN - 8;
      2'b01:   sh = XLEN - 16;
      2'b10:   sh = XLEN - 32;
      default: sh = 0;
    endcase
    up = raw << sh;
    if (f3[2]) load_ext = up >> sh;
    else       load_ext = $signed(up) >>> sh;
  endfunction

  // Decode access size, alignment and store strobes from the incoming bundle.
  always_comb begin
    offset_s = alu_result[OW-1:0];
    case (funct3[1:0])
      2'b00:   begin size_mask_s = OW'(3'd0); strb_base_s = NB'(8'h01); end
      2'b01:   begin size_mask_s = OW'(3'd1); strb_base_s = NB'(8'h03); end
      2'b10:   begin size_mask_s = OW'(3'd3); strb_base_s = NB'(8'h0F); end
      default: begin size_mask_s = OW'(3'd7); strb_base_s = NB'(8'hFF); end
    endcase
    misaligned_s    = |(offset_s & size_mask_s);
    eff_off_s       = offset_s & ~size_mask_s;
    misalign_trap_s = TRAP_EN & misaligned_s;
  end

  assign rdata_shift_s = dmem_rdata >> {off_r, 3'b000};
  assign load_val_s    = load_ext(rdata_shift_s, funct3_r);
  assign mem_busy      = (state != IDLE);

  // Stage FSM, bus request registers and writeback bundle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                <= IDLE;
      off_r                <= {OW{1'b0}};
      funct3_r             <= 3'b000;
      rd_r                 <= 5'd0;
      rwe_r                <= 1'b0;
      pc_r                 <= {XLEN{1'b0}};
      addr_r               <= {XLEN{1'b0}};
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= {XLEN{1'b0}};
      dmem_wdata           <= {XLEN{1'b0}};
      dmem_wstrb           <= {NB{1'b0}};
      wb_data              <= {XLEN{1'b0}};
      rd_out               <= 5'd0;
      reg_write_enable_out <= 1'b0;
      pc_out               <= {XLEN{1'b0}};
      trap_out             <= 1'b0;
      trap_cause_out       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            reg_write_enable_out <= 1'b0;
            trap_out             <= 1'b0;
          end else if (trap_in || ((mem_read || mem_write) && misalign_trap_s)) begin
            wb_data              <= alu_result;
            rd_out               <= rd;
            pc_out               <= pc_in;
            reg_write_enable_out <= 1'b0;
            trap_out             <= 1'b1;
            if (trap_in)        trap_cause_out <= trap_cause_in;
            else if (mem_write) trap_cause_out <= 4'd6;
            else                trap_cause_out <= 4'd4;
          end else if (mem_read || mem_write) begin
            off_r                <= eff_off_s;
            funct3_r             <= funct3;
            rd_r                 <= rd;
            rwe_r                <= reg_write_enable;
            pc_r                 <= pc_in;
            addr_r               <= alu_result;
            dmem_req             <= 1'b1;
            dmem_we              <= mem_write;
            dmem_addr            <= {alu_result[XLEN-1:OW], {OW{1'b0}}};
            dmem_wdata           <= rs2_data << {eff_off_s, 3'b000};
            dmem_wstrb           <= mem_write ? (strb_base_s << eff_off_s) : {NB{1'b0}};
            reg_write_enable_out <= 1'b0;
            trap_out             <= 1'b0;
            state                <= REQ;
          end else begin
            wb_data              <= alu_result;
            rd_out               <= rd;
            pc_out               <= pc_in;
            reg_write_enable_out <= reg_write_enable;
            trap_out             <= 1'b0;
            trap_cause_out       <= 4'd0;
          end
        end
        REQ: begin
          reg_write_enable_out <= 1'b0;
          trap_out             <= 1'b0;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_data        <= addr_r;
              rd_out         <= rd_r;
              pc_out         <= pc_r;
              trap_cause_out <= 4'd0;
              state          <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          reg_write_enable_out <= 1'b0;
          trap_out             <= 1'b0;
          if (dmem_rvalid) begin
            wb_data              <= load_val_s;
            rd_out               <= rd_r;
            pc_out               <= pc_r;
            reg_write_enable_out <= rwe_r;
            trap_cause_out       <= 4'd0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access (XLEN=64); inputs driven and outputs sampled on the falling edge.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] alu_result, rs2_data, pc_in;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write_enable, mem_read, mem_write, trap_in, flush;
  logic [3:0]  trap_cause_in;
  logic        mem_busy, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data, pc_out;
  logic [7:0]  dmem_wstrb;
  logic [4:0]  rd_out;
  logic        reg_write_enable_out, trap_out;
  logic [3:0]  trap_cause_out;
  int passed = 0;
  int total  = 0;

  mem_access #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn), .alu_result(alu_result), .rs2_data(rs2_data), .pc_in(pc_in),
    .rd(rd), .funct3(funct3), .reg_write_enable(reg_write_enable), .mem_read(mem_read),
    .mem_write(mem_write), .trap_in(trap_in), .trap_cause_in(trap_cause_in), .flush(flush),
    .mem_busy(mem_busy), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_data(wb_data), .rd_out(rd_out),
    .reg_write_enable_out(reg_write_enable_out), .pc_out(pc_out), .trap_out(trap_out),
    .trap_cause_out(trap_cause_out)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alu_result = 64'h0; rs2_data = 64'h0; pc_in = 64'h0; rd = 5'd0; funct3 = 3'b000;
    reg_write_enable = 1'b0; mem_read = 1'b0; mem_write = 1'b0; trap_in = 1'b0;
    trap_cause_in = 4'd0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    total++; if (wb_data !== 64'h0) $display("FAIL reset_wb_data: got %h expected 0", wb_data); else passed++;
    total++; if (dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); else passed++;
    total++; if (mem_busy !== 1'b0) $display("FAIL reset_mem_busy: got %b expected 0", mem_busy); else passed++;
    total++; if ({reg_write_enable_out, trap_out, trap_cause_out, rd_out} !== 11'h0) $display("FAIL reset_ctrl: got %h expected 0", {reg_write_enable_out, trap_out, trap_cause_out, rd_out}); else passed++;
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    alu_result = 64'h55; reg_write_enable = 1'b1; rd = 5'd5; pc_in = 64'h100;
    @(negedge clk);
    total++; if (wb_data !== 64'h55) $display("FAIL alu_wb_data: got %h expected 55", wb_data); else passed++;
    total++; if (reg_write_enable_out !== 1'b1 || rd_out !== 5'd5) $display("FAIL alu_rwe_rd: got %b/%0d expected 1/5", reg_write_enable_out, rd_out); else passed++;
    total++; if (pc_out !== 64'h100) $display("FAIL alu_pc: got %h expected 100", pc_out); else passed++;
    total++; if (dmem_req !== 1'b0 || mem_busy !== 1'b0) $display("FAIL alu_no_req: got %b/%b expected 0/0", dmem_req, mem_busy); else passed++;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_load_lw();
    alu_result = 64'h1004; mem_read = 1'b1; funct3 = 3'b010; rd = 5'd7; reg_write_enable = 1'b1; pc_in = 64'h200;
    @(negedge clk);
    clear_inputs();
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) $display("FAIL lw_req: got req=%b we=%b expected 1/0", dmem_req, dmem_we); else passed++;
    total++; if (dmem_addr !== 64'h1000) $display("FAIL lw_addr: got %h expected 1000", dmem_addr); else passed++;
    total++; if (mem_busy !== 1'b1 || reg_write_enable_out !== 1'b0) $display("FAIL lw_busy_bubble: got %b/%b expected 1/0", mem_busy, reg_write_enable_out); else passed++;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (dmem_req !== 1'b0 || mem_busy !== 1'b1) $display("FAIL lw_wait: got req=%b busy=%b expected 0/1", dmem_req, mem_busy); else passed++;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h80000000_00000000;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (wb_data !== 64'hFFFFFFFF_80000000) $display("FAIL lw_wb_data: got %h expected ffffffff80000000", wb_data); else passed++;
    total++; if (reg_write_enable_out !== 1'b1 || rd_out !== 5'd7 || pc_out !== 64'h200) $display("FAIL lw_wb_ctrl: got %b/%0d/%h expected 1/7/200", reg_write_enable_out, rd_out, pc_out); else passed++;
    total++; if (mem_busy !== 1'b0) $display("FAIL lw_idle: got %b expected 0", mem_busy); else passed++;
    @(negedge clk);
  endtask

  task automatic test_store_sb();
    alu_result = 64'h2003; rs2_data = 64'hAB; mem_write = 1'b1; funct3 = 3'b000; pc_in = 64'h300;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || mem_busy !== 1'b1) $display("FAIL sb_req_%0d: got req=%b we=%b busy=%b expected 1/1/1", i, dmem_req, dmem_we, mem_busy); else passed++;
      total++; if (dmem_wstrb !== 8'h08 || dmem_wdata[31:24] !== 8'hAB || dmem_addr !== 64'h2000) $display("FAIL sb_bus_%0d: got strb=%h wdata=%h addr=%h expected 08/ab/2000", i, dmem_wstrb, dmem_wdata[31:24], dmem_addr); else passed++;
      @(negedge clk);
    end
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (mem_busy !== 1'b0 || dmem_req !== 1'b0) $display("FAIL sb_done: got busy=%b req=%b expected 0/0", mem_busy, dmem_req); else passed++;
    total++; if (reg_write_enable_out !== 1'b0 || pc_out !== 64'h300) $display("FAIL sb_wb: got rwe=%b pc=%h expected 0/300", reg_write_enable_out, pc_out); else passed++;
  endtask

  task automatic test_store_sd();
    alu_result = 64'h2008; rs2_data = 64'h11223344_55667788; mem_write = 1'b1; funct3 = 3'b011;
    @(negedge clk);
    clear_inputs();
    total++; if (dmem_wstrb !== 8'hFF || dmem_wdata !== 64'h11223344_55667788 || dmem_addr !== 64'h2008) $display("FAIL sd_bus: got strb=%h wdata=%h addr=%h expected ff/1122334455667788/2008", dmem_wstrb, dmem_wdata, dmem_addr); else passed++;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (mem_busy !== 1'b0 || dmem_req !== 1'b0) $display("FAIL sd_done: got busy=%b req=%b expected 0/0", mem_busy, dmem_req); else passed++;
  endtask

  task automatic test_misalign();
    alu_result = 64'h3001; mem_read = 1'b1; funct3 = 3'b001; rd = 5'd3; reg_write_enable = 1'b1;
    @(negedge clk);
    clear_inputs();
`ifdef MEM_MISALIGN_TRAP_EN
    total++; if (trap_out !== 1'b1 || trap_cause_out !== 4'd4) $display("FAIL lh_trap: got %b/%0d expected 1/4", trap_out, trap_cause_out); else passed++;
    total++; if (wb_data !== 64'h3001 || dmem_req !== 1'b0 || reg_write_enable_out !== 1'b0) $display("FAIL lh_trap_out: got wb=%h req=%b rwe=%b expected 3001/0/0", wb_data, dmem_req, reg_write_enable_out); else passed++;
`else
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 64'h3000) $display("FAIL lh_req: got req=%b addr=%h expected 1/3000", dmem_req, dmem_addr); else passed++;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h00000000_00C3F1A2;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (wb_data !== 64'hFFFFFFFF_FFFFF1A2 || trap_out !== 1'b0) $display("FAIL lh_aligned: got wb=%h trap=%b expected fffffffffffff1a2/0", wb_data, trap_out); else passed++;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    alu_result = 64'h4000; mem_read = 1'b1; funct3 = 3'b011; rd = 5'd9; reg_write_enable = 1'b1;
    @(negedge clk);
    clear_inputs();
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    total++; if (mem_busy !== 1'b1) $display("FAIL rst_mid_wait: got %b expected 1", mem_busy); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0 || mem_busy !== 1'b0 || wb_data !== 64'h0 || pc_out !== 64'h0) $display("FAIL rst_mid_async: got req=%b busy=%b wb=%h pc=%h expected all 0", dmem_req, mem_busy, wb_data, pc_out); else passed++;
    @(negedge clk);
    resetn = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (wb_data !== 64'h0 || reg_write_enable_out !== 1'b0 || rd_out !== 5'd0) $display("FAIL rst_mid_ignore: got wb=%h rwe=%b rd=%0d expected 0/0/0", wb_data, reg_write_enable_out, rd_out); else passed++;
    alu_result = 64'h5006; mem_read = 1'b1; funct3 = 3'b100; rd = 5'd4; reg_write_enable = 1'b1;
    @(negedge clk);
    clear_inputs();
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h00FE0000_00000000;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (wb_data !== 64'hFE || rd_out !== 5'd4 || reg_write_enable_out !== 1'b1) $display("FAIL rst_mid_next_lbu: got wb=%h rd=%0d rwe=%b expected fe/4/1", wb_data, rd_out, reg_write_enable_out); else passed++;
    @(negedge clk);
  endtask

  task automatic test_trap_in();
    trap_in = 1'b1; trap_cause_in = 4'd2; mem_write = 1'b1; alu_result = 64'h6000; reg_write_enable = 1'b1;
    @(negedge clk);
    clear_inputs();
    total++; if (trap_out !== 1'b1 || trap_cause_out !== 4'd2 || reg_write_enable_out !== 1'b0) $display("FAIL trap_in_out: got %b/%0d/%b expected 1/2/0", trap_out, trap_cause_out, reg_write_enable_out); else passed++;
    total++; if (dmem_req !== 1'b0 || mem_busy !== 1'b0) $display("FAIL trap_in_no_req: got %b/%b expected 0/0", dmem_req, mem_busy); else passed++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    alu_result = 64'h77; reg_write_enable = 1'b1; rd = 5'd1;
    @(negedge clk);
    alu_result = 64'h7000; mem_read = 1'b1; funct3 = 3'b010; flush = 1'b1;
    @(negedge clk);
    clear_inputs();
    total++; if (dmem_req !== 1'b0 || mem_busy !== 1'b0) $display("FAIL flush_no_req: got %b/%b expected 0/0", dmem_req, mem_busy); else passed++;
    total++; if (reg_write_enable_out !== 1'b0 || trap_out !== 1'b0 || wb_data !== 64'h77) $display("FAIL flush_bubble: got rwe=%b trap=%b wb=%h expected 0/0/77", reg_write_enable_out, trap_out, wb_data); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    alu_result = 64'h1004; mem_read = 1'b1; funct3 = 3'b110; rd = 5'd8; reg_write_enable = 1'b1; pc_in = 64'h400;
    @(negedge clk);
    mem_read = 1'b0; funct3 = 3'b000; alu_result = 64'h99; rd = 5'd10; pc_in = 64'h404;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h80000001_00000000;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    total++; if (wb_data !== 64'h00000000_80000001 || rd_out !== 5'd8 || pc_out !== 64'h400) $display("FAIL b2b_lwu: got wb=%h rd=%0d pc=%h expected 80000001/8/400", wb_data, rd_out, pc_out); else passed++;
    @(negedge clk);
    clear_inputs();
    total++; if (wb_data !== 64'h99 || rd_out !== 5'd10 || reg_write_enable_out !== 1'b1) $display("FAIL b2b_next: got wb=%h rd=%0d rwe=%b expected 99/10/1", wb_data, rd_out, reg_write_enable_out); else passed++;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_alu();
    test_load_lw();
    test_store_sb();
    test_store_sd();
    test_misalign();
    test_reset_mid();
    test_trap_in();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
